// File: rtl/led_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl_if
//   Signal bundle between the key/debounce logic (master) and the LED mode
//   controller (slave).
//
//   mode_next  : 1-cycle pulse, advance mode OFF->SLOW->FAST->ON->OFF
//   mode_load  : 1-cycle pulse, load mode from mode_sel (wins over mode_next)
//   mode_sel   : mode to load, 0=OFF 1=SLOW 2=FAST 3=ON
//   mode       : current mode (registered)
//   tick_flag  : 1-cycle pulse at the tick counter terminal count (registered)
//   led_out    : LED drive, active-high (registered)
// ---------------------------------------------------------------------------
interface led_mode_ctrl_if;
    logic       mode_next;
    logic       mode_load;
    logic [1:0] mode_sel;
    logic [1:0] mode;
    logic       tick_flag;
    logic       led_out;

    modport master (
        output mode_next,
        output mode_load,
        output mode_sel,
        input  mode,
        input  tick_flag,
        input  led_out
    );

    modport slave (
        input  mode_next,
        input  mode_load,
        input  mode_sel,
        output mode,
        output tick_flag,
        output led_out
    );
endinterface : led_mode_ctrl_if

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
//   Status LED mode controller. One shared tick counter is sequenced through
//   four display modes (OFF, SLOW blink, FAST blink, ON); its terminal count
//   is reloaded per mode. Any mode_next/mode_load pulse is a mode change
//   event: the counter restarts, any pending tick is dropped and the LED is
//   forced to the entry value of the new mode.
//
//   Ports:
//     sys_clk    : system clock, rising edge
//     sys_rst_n  : asynchronous active-low reset
//     bus        : led_mode_ctrl_if.slave (mode_next, mode_load, mode_sel in;
//                  mode, tick_flag, led_out out)
//
//   Optional feature (macro LED_DIM_EN): ON mode is dimmed by a 4-bit PWM
//   giving DIM_DUTY high cycles out of 16. Without the macro ON is steady 1.
// ---------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int unsigned      CNT_W    = 25,
    parameter logic [CNT_W-1:0] SLOW_MAX = 25'd24_999_999,
    parameter logic [CNT_W-1:0] FAST_MAX = 25'd4_999_999,
    parameter logic [3:0]       DIM_DUTY = 4'd4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    led_mode_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_max;
    logic             tick_q, tick_d;
    logic             led_q, led_d;
    logic             mode_evt;
    logic             on_led;

`ifdef LED_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    // Low DIM_DUTY counts of each 16-cycle PWM window drive the LED high.
    assign on_led = (pwm_q < DIM_DUTY);

    always_comb begin
        pwm_d = pwm_q;
        if (mode_evt) begin
            pwm_d = 4'd0;
        end else if (mode_q == MODE_ON) begin
            pwm_d = pwm_q + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    // Duty is meaningless for a steady ON LED; tie it off so it is referenced.
    logic unused_dim_duty;
    assign unused_dim_duty = ^DIM_DUTY;
    assign on_led          = 1'b1;
`endif

    assign mode_evt = bus.mode_load | bus.mode_next;
    assign cur_max  = (mode_q == MODE_FAST) ? FAST_MAX : SLOW_MAX;

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = '0;
        tick_d = 1'b0;
        led_d  = led_q;

        if (bus.mode_load) begin
            mode_d = mode_t'(bus.mode_sel);
        end else if (bus.mode_next) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end

        if (mode_evt) begin
            // Entry edge: counter and tick restart, a coincident toggle is lost.
            led_d = (mode_d == MODE_ON);
        end else begin
            unique case (mode_q)
                MODE_SLOW, MODE_FAST: begin
                    cnt_d  = (cnt_q == cur_max) ? '0 : cnt_q + CNT_ONE;
                    // Registered one cycle early so tick_flag lines up with
                    // cnt == cur_max.
                    tick_d = (cnt_q == cur_max - CNT_ONE);
                    if (tick_q) begin
                        led_d = ~led_q;
                    end
                end
                MODE_OFF: led_d = 1'b0;
                MODE_ON:  led_d = on_led;
                default:  led_d = 1'b0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            led_q  <= led_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.tick_flag = tick_q;
    assign bus.led_out   = led_q;

endmodule : led_mode_ctrl

// File: tb/tb_led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mode_ctrl
//   Directed bench for led_mode_ctrl with SLOW_MAX=9, FAST_MAX=3, DIM_DUTY=4.
//   Each driven cycle pushes the expected {mode, tick_flag, led_out} computed
//   from the mode and the number of cycles since mode entry; the entry is
//   popped and compared 1 time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_led_mode_ctrl;

    localparam int SLOW_T = 9;
    localparam int FAST_T = 3;
    localparam int DIM_T  = 4;

    typedef struct packed {
        logic [1:0] mode;
        logic       tick;
        logic       led;
    } obs_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .CNT_W    (25),
        .SLOW_MAX (25'd9),
        .FAST_MAX (25'd3),
        .DIM_DUTY (4'd4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode = 0;   // expected mode
    int   k      = 0;   // cycles since mode entry

    // Expected outputs for a mode, k cycles after its entry edge.
    function automatic obs_t exp_of(input int md, input int kk);
        obs_t r;
        int   per;
        r.mode = 2'(md);
        r.tick = 1'b0;
        r.led  = 1'b0;
        if (md == 1 || md == 2) begin
            per    = (md == 1) ? SLOW_T + 1 : FAST_T + 1;
            r.tick = ((kk % per) == per - 1);
            r.led  = (((kk / per) % 2) == 1);
        end else if (md == 3) begin
`ifdef LED_DIM_EN
            r.led = (kk == 0) || (((kk - 1) % 16) < DIM_T);
`else
            r.led = 1'b1;
`endif
        end
        return r;
    endfunction

    task automatic compare(input string tag);
        obs_t obs;
        obs_t exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed mode=%0d tick=%b led=%b",
                   tag, bus.mode, bus.tick_flag, bus.led_out);
        end else begin
            exp = exp_q.pop_front();
            obs = '{mode: bus.mode, tick: bus.tick_flag, led: bus.led_out};
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s k=%0d: observed mode=%0d tick=%b led=%b, expected mode=%0d tick=%b led=%b",
                       tag, k, obs.mode, obs.tick, obs.led, exp.mode, exp.tick, exp.led);
            end
        end
    endtask

    // Drive one cycle of inputs, predict, then check after the edge.
    task automatic cycle(input logic nxt, input logic ld, input logic [1:0] sel,
                         input string tag);
        bus.mode_next = nxt;
        bus.mode_load = ld;
        bus.mode_sel  = sel;
        if (ld) begin
            m_mode = int'(sel);
            k      = 0;
        end else if (nxt) begin
            m_mode = (m_mode + 1) % 4;
            k      = 0;
        end else begin
            k++;
        end
        exp_q.push_back(exp_of(m_mode, k));
        @(posedge sys_clk);
        #1;
        bus.mode_next = 1'b0;
        bus.mode_load = 1'b0;
        compare(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 2'd0, tag);
        end
    endtask

    task automatic expect_reset(input string tag);
        m_mode = 0;
        k      = 0;
        exp_q.push_back(exp_of(0, 0));
        compare(tag);
    endtask

    initial begin
        bus.mode_next = 1'b0;
        bus.mode_load = 1'b0;
        bus.mode_sel  = 2'd0;

        // Reset from time zero, then idle in OFF.
        #2;
        expect_reset("reset_initial");
        #20;
        sys_rst_n = 1'b1;
        run(50, "idle_off");

        // SLOW: tick every 10 cycles, LED period 20.
        cycle(1'b1, 1'b0, 2'd0, "next_to_slow");
        run(45, "slow");

        // FAST, ON, then wrap back to OFF.
        cycle(1'b1, 1'b0, 2'd0, "next_to_fast");
        run(20, "fast");
        cycle(1'b1, 1'b0, 2'd0, "next_to_on");
        run(20, "on");
        cycle(1'b1, 1'b0, 2'd0, "next_wrap_off");
        run(20, "wrap_off");

        // mode_load wins over a coincident mode_next.
        cycle(1'b0, 1'b1, 2'd1, "load_slow");
        run(5, "slow_pre_load");
        cycle(1'b1, 1'b1, 2'd2, "load_beats_next");
        run(10, "fast_after_load");

        // Reloading the current mode restarts the counter.
        run(1, "fast_mid");
        cycle(1'b0, 1'b1, 2'd2, "reload_fast");
        run(6, "fast_after_reload");

        // mode_next in the tick cycle while led_out=1: toggle discarded.
        cycle(1'b0, 1'b1, 2'd1, "load_slow2");
        run(19, "slow_to_tick");
        cycle(1'b1, 1'b0, 2'd0, "next_on_tick");
        run(8, "fast_after_discard");

        // ON via load (dimmed when LED_DIM_EN is defined).
        cycle(1'b0, 1'b1, 2'd3, "load_on");
        run(40, "on_load");

        // Asynchronous reset in the middle of SLOW blinking.
        cycle(1'b0, 1'b1, 2'd1, "load_slow3");
        run(12, "slow_pre_reset");
        sys_rst_n = 1'b0;
        #1;
        expect_reset("reset_midop");
        @(posedge sys_clk);
        #1;
        expect_reset("reset_hold");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run(10, "after_reset");
        cycle(1'b1, 1'b0, 2'd0, "next_after_reset");
        run(12, "slow_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_mode_ctrl
